mem_access_unit: RTL and testbench

Memory-stage load/store controller: takes the M-stage memory request (address from the ALU result, store data, access size), runs it over a single-outstanding req/ack data bus, and stalls the pipeline until the transfer ends. It produces READ_DATA_M, aligned and extended, for the M/W pipeline register. It sits between the execute/memory pipeline register and the M/W register, and is the producer side of the data that the writeback path consumes.

---
 rtl/mem_access_unit.sv | 133 +++++++++++++
 tb/tb_mem_access_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory-stage load/store controller: issues one M-stage access at a time on a
// req/ack data bus, stalls the pipeline until it completes, returns extended load data.
module mem_access_unit #(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 255
) (
   input  logic             CLK,
   input  logic             CLR,
   input  logic             MEM_READ_M,
   input  logic             MEM_WRITE_M,
   input  logic [1:0]       MEM_SIZE_M,
   input  logic             MEM_SIGNED_M,
   input  logic [WIDTH-1:0] ADDR_M,
   input  logic [WIDTH-1:0] WRITE_DATA_M,
   output logic             STALL_M,
   output logic [WIDTH-1:0] READ_DATA_M,
   output logic             MISALIGN_M,
   output logic             TIMEOUT_M,
   output logic             BUS_REQ,
   output logic             BUS_WE,
   output logic [WIDTH-1:0] BUS_ADDR,
   output logic [3:0]       BUS_BE,
   output logic [WIDTH-1:0] BUS_WDATA,
   input  logic [WIDTH-1:0] BUS_RDATA,
   input  logic             BUS_ACK
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t     state;
   logic [7:0] cnt;
   logic [1:0] size_q;
   logic       signed_q;
   logic [1:0] off_q;

   logic             op;
   logic             aligned;
   logic [3:0]       be_n;
   logic [WIDTH-1:0] wdata_n;
   logic [7:0]       lane_b;
   logic [15:0]      lane_h;
   logic [WIDTH-1:0] ext;

   assign op = MEM_READ_M | MEM_WRITE_M;

   always_comb begin
      aligned = 1'b1;
      be_n    = 4'b1111;
      wdata_n = WRITE_DATA_M;
      case (MEM_SIZE_M)
         2'b00: begin
            be_n    = 4'b0001 << ADDR_M[1:0];
            wdata_n = {4{WRITE_DATA_M[7:0]}};
         end
         2'b01: begin
            aligned = ~ADDR_M[0];
            be_n    = ADDR_M[1] ? 4'b1100 : 4'b0011;
            wdata_n = {2{WRITE_DATA_M[15:0]}};
         end
         default: aligned = (ADDR_M[1:0] == 2'b00);
      endcase
   end

   // Extraction uses the lane info latched at issue, not the live M-stage inputs.
   always_comb begin
      lane_b = BUS_RDATA[{off_q, 3'b000} +: 8];
      lane_h = BUS_RDATA[{off_q[1], 4'b0000} +: 16];
      case (size_q)
         2'b00:   ext = signed_q ? {{(WIDTH-8){lane_b[7]}}, lane_b}   : {{(WIDTH-8){1'b0}}, lane_b};
         2'b01:   ext = signed_q ? {{(WIDTH-16){lane_h[15]}}, lane_h} : {{(WIDTH-16){1'b0}}, lane_h};
         default: ext = BUS_RDATA;
      endcase
   end

   assign STALL_M = ~CLR & (((state == IDLE) & op & aligned) | (state == BUSY));

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         state       <= IDLE;
         cnt         <= '0;
         size_q      <= '0;
         signed_q    <= 1'b0;
         off_q       <= '0;
         READ_DATA_M <= '0;
         MISALIGN_M  <= 1'b0;
         TIMEOUT_M   <= 1'b0;
         BUS_REQ     <= 1'b0;
         BUS_WE      <= 1'b0;
         BUS_ADDR    <= '0;
         BUS_BE      <= '0;
         BUS_WDATA   <= '0;
      end else begin
         MISALIGN_M <= 1'b0;
         TIMEOUT_M  <= 1'b0;
         case (state)
            IDLE: begin
               if (op && aligned) begin
                  BUS_REQ   <= 1'b1;
                  BUS_WE    <= MEM_WRITE_M & ~MEM_READ_M;
                  BUS_ADDR  <= {ADDR_M[WIDTH-1:2], 2'b00};
                  BUS_BE    <= be_n;
                  BUS_WDATA <= wdata_n;
                  size_q    <= MEM_SIZE_M;
                  signed_q  <= MEM_SIGNED_M;
                  off_q     <= ADDR_M[1:0];
                  cnt       <= '0;
                  state     <= BUSY;
               end else if (op) begin
                  READ_DATA_M <= '0;
                  MISALIGN_M  <= 1'b1;
               end
            end
            BUSY: begin
               if (BUS_ACK) begin
                  BUS_REQ <= 1'b0;
                  if (!BUS_WE) READ_DATA_M <= ext;
                  state <= DONE;
               end else if (cnt == 8'(TIMEOUT - 1)) begin
                  BUS_REQ     <= 1'b0;
                  READ_DATA_M <= '0;
                  TIMEOUT_M   <= 1'b1;
                  state       <= DONE;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases with literal expectations, then random
// ops checked every cycle against a transaction-level model.
module tb_mem_access_unit;

   localparam int TO = 4;

   logic        CLK = 1'b0;
   logic        CLR = 1'b1;
   logic        MEM_READ_M = 0, MEM_WRITE_M = 0, MEM_SIGNED_M = 0;
   logic [1:0]  MEM_SIZE_M = 0;
   logic [31:0] ADDR_M = 0, WRITE_DATA_M = 0, BUS_RDATA = 0;
   logic        BUS_ACK = 0;
   logic        STALL_M, MISALIGN_M, TIMEOUT_M, BUS_REQ, BUS_WE;
   logic [31:0] READ_DATA_M, BUS_ADDR, BUS_WDATA;
   logic [3:0]  BUS_BE;

   mem_access_unit #(.WIDTH(32), .TIMEOUT(TO)) dut (
      .CLK(CLK), .CLR(CLR), .MEM_READ_M(MEM_READ_M), .MEM_WRITE_M(MEM_WRITE_M),
      .MEM_SIZE_M(MEM_SIZE_M), .MEM_SIGNED_M(MEM_SIGNED_M), .ADDR_M(ADDR_M),
      .WRITE_DATA_M(WRITE_DATA_M), .STALL_M(STALL_M), .READ_DATA_M(READ_DATA_M),
      .MISALIGN_M(MISALIGN_M), .TIMEOUT_M(TIMEOUT_M), .BUS_REQ(BUS_REQ), .BUS_WE(BUS_WE),
      .BUS_ADDR(BUS_ADDR), .BUS_BE(BUS_BE), .BUS_WDATA(BUS_WDATA),
      .BUS_RDATA(BUS_RDATA), .BUS_ACK(BUS_ACK)
   );

   always #5 CLK = ~CLK;

   int total = 0, bad = 0;

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model of the bus view of one access, in plain arithmetic.
   function automatic bit m_al(input logic [1:0] sz, input logic [31:0] a);
      if (sz == 2'd0) return 1;
      if (sz == 2'd1) return (a % 2) == 0;
      return (a % 4) == 0;
   endfunction

   function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
      if (sz == 2'd0) return 4'(1 << (a % 4));
      if (sz == 2'd1) return ((a % 4) >= 2) ? 4'hC : 4'h3;
      return 4'hF;
   endfunction

   function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] d);
      if (sz == 2'd0) return (d & 32'hFF) * 32'h01010101;
      if (sz == 2'd1) return (d & 32'hFFFF) * 32'h00010001;
      return d;
   endfunction

   function automatic logic [31:0] m_ld(input logic [1:0] sz, input logic sg,
                                        input logic [31:0] a, input logic [31:0] r);
      logic [31:0] v;
      if (sz == 2'd0) begin
         v = (r >> (8 * (a % 4))) & 32'hFF;
         if (sg && v >= 32'h80) v = v | 32'hFFFFFF00;
      end else if (sz == 2'd1) begin
         v = (r >> (16 * ((a % 4) / 2))) & 32'hFFFF;
         if (sg && v >= 32'h8000) v = v | 32'hFFFF0000;
      end else begin
         v = r;
      end
      return v;
   endfunction

   // Per-cycle expectations written by the driver, compared on every negedge.
   bit          chk_en = 0;
   logic        e_stall = 0, e_req = 0, e_we = 0, e_mis = 0, e_to = 0;
   logic [31:0] e_addr = 0, e_wd = 0, e_rd = 0;
   logic [3:0]  e_be = 0;
   int          n_stall = 0, n_req = 0, n_mis = 0, n_to = 0;
   logic [31:0] last_addr = 0, last_wd = 0;
   logic [3:0]  last_be = 0;
   logic        last_we = 0;

   always @(negedge CLK) begin
      if (chk_en) begin
         cmp("stall", 32'(STALL_M), 32'(e_stall));
         cmp("bus_req", 32'(BUS_REQ), 32'(e_req));
         cmp("read_data", READ_DATA_M, e_rd);
         cmp("misalign", 32'(MISALIGN_M), 32'(e_mis));
         cmp("timeout", 32'(TIMEOUT_M), 32'(e_to));
         if (e_req) begin
            cmp("bus_we", 32'(BUS_WE), 32'(e_we));
            cmp("bus_addr", BUS_ADDR, e_addr);
            cmp("bus_be", 32'(BUS_BE), 32'(e_be));
            cmp("bus_wdata", BUS_WDATA, e_wd);
         end
      end
      if (STALL_M)    n_stall++;
      if (MISALIGN_M) n_mis++;
      if (TIMEOUT_M)  n_to++;
      if (BUS_REQ) begin
         n_req++;
         last_addr = BUS_ADDR; last_be = BUS_BE; last_wd = BUS_WDATA; last_we = BUS_WE;
      end
   end

   logic [31:0] rd_model = 0;
   bit          mis_next = 0;

   task automatic next_cycle();
      @(posedge CLK); #1;
   endtask

   // d = cycle (1..TO) in which ack is given after the request; 0 = never acked.
   task automatic do_op(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                        input int d);
      bit op, al, ld;
      op = rd | wr;
      al = m_al(sz, a);
      ld = rd;
      MEM_READ_M = rd; MEM_WRITE_M = wr; MEM_SIZE_M = sz; MEM_SIGNED_M = sg;
      ADDR_M = a; WRITE_DATA_M = wd;
      BUS_ACK = 1'($urandom); BUS_RDATA = $urandom;
      e_mis = mis_next; mis_next = 0; e_to = 0; e_rd = rd_model;
      e_stall = op & al; e_req = 0;
      if (!(op && al)) begin
         if (op) begin mis_next = 1; rd_model = 0; end
         next_cycle();
         return;
      end
      e_we = wr & ~rd; e_addr = a & 32'hFFFFFFFC; e_be = m_be(sz, a); e_wd = m_wd(sz, wd);
      for (int i = 1; i <= ((d > 0) ? d : TO); i++) begin
         next_cycle();
         e_stall = 1; e_req = 1; e_mis = 0;
         BUS_ACK = (i == d);
         BUS_RDATA = (i == d) ? rdat : $urandom;
      end
      next_cycle();
      BUS_ACK = 1'($urandom); BUS_RDATA = $urandom;
      if (d == 0) rd_model = 0;
      else if (ld) rd_model = m_ld(sz, sg, a, rdat);
      e_stall = 0; e_req = 0; e_to = (d == 0); e_rd = rd_model;
      next_cycle();
   endtask

   task automatic idle_op();
      do_op(0, 0, 2'd0, 0, 32'h0, 32'h0, 32'h0, 0);
   endtask

   initial begin
      int b_st, b_rq, b_ms, b_to;
      #2;
      cmp("rst_stall", 32'(STALL_M), 0);
      cmp("rst_req", 32'(BUS_REQ), 0);
      cmp("rst_rd", READ_DATA_M, 0);
      cmp("rst_addr", BUS_ADDR, 0);
      cmp("rst_be", 32'(BUS_BE), 0);
      cmp("rst_wd", BUS_WDATA, 0);
      cmp("rst_pulses", {30'd0, MISALIGN_M, TIMEOUT_M}, 0);
      next_cycle();
      CLR = 0;
      chk_en = 1;
      idle_op();

      // Word load, ack two cycles after the request.
      b_st = n_stall;
      do_op(1, 0, 2'd2, 0, 32'h100, 0, 32'hDEADBEEF, 2);
      cmp("lit_word_stall", 32'(n_stall - b_st), 3);
      cmp("lit_word_addr", last_addr, 32'h100);
      cmp("lit_word_be", 32'(last_be), 32'hF);
      cmp("lit_word_we", 32'(last_we), 0);
      cmp("lit_word_rd", READ_DATA_M, 32'hDEADBEEF);

      do_op(1, 0, 2'd0, 1, 32'h103, 0, 32'h80112233, 1);
      cmp("lit_sbyte_be", 32'(last_be), 32'h8);
      cmp("lit_sbyte_rd", READ_DATA_M, 32'hFFFFFF80);
      do_op(1, 0, 2'd0, 0, 32'h103, 0, 32'h80112233, 1);
      cmp("lit_ubyte_rd", READ_DATA_M, 32'h00000080);

      b_st = n_stall;
      do_op(0, 1, 2'd1, 0, 32'h202, 32'h0000ABCD, 32'h12345678, 1);
      cmp("lit_hst_stall", 32'(n_stall - b_st), 2);
      cmp("lit_hst_we", 32'(last_we), 1);
      cmp("lit_hst_be", 32'(last_be), 32'hC);
      cmp("lit_hst_wd", last_wd, 32'hABCDABCD);
      cmp("lit_hst_rd", READ_DATA_M, 32'h00000080);

      b_rq = n_req; b_ms = n_mis; b_st = n_stall;
      do_op(1, 0, 2'd2, 0, 32'h101, 0, 0, 1);
      idle_op();
      cmp("lit_mis_req", 32'(n_req - b_rq), 0);
      cmp("lit_mis_stall", 32'(n_stall - b_st), 0);
      cmp("lit_mis_pulse", 32'(n_mis - b_ms), 1);
      cmp("lit_mis_rd", READ_DATA_M, 0);

      do_op(1, 0, 2'd2, 0, 32'h300, 0, 32'h55AA55AA, 1);
      b_rq = n_req; b_to = n_to;
      do_op(1, 0, 2'd2, 0, 32'h400, 0, 0, 0);
      cmp("lit_to_req", 32'(n_req - b_rq), TO);
      cmp("lit_to_pulse", 32'(n_to - b_to), 1);
      cmp("lit_to_rd", READ_DATA_M, 0);

      // Reset in the middle of a transfer, then a stray ack.
      do_op(1, 0, 2'd2, 0, 32'h500, 0, 32'h11111111, 1);
      MEM_READ_M = 1; MEM_WRITE_M = 0; MEM_SIZE_M = 2'd2; ADDR_M = 32'h600; BUS_ACK = 0;
      e_mis = 0; e_to = 0; e_rd = rd_model; e_stall = 1; e_req = 0;
      next_cycle();
      e_stall = 1; e_req = 1; e_we = 0; e_addr = 32'h600; e_be = 4'hF; e_wd = 0;
      next_cycle();
      chk_en = 0;
      #2 CLR = 1;
      MEM_READ_M = 0;
      #1;
      cmp("clr_req", 32'(BUS_REQ), 0);
      cmp("clr_stall", 32'(STALL_M), 0);
      cmp("clr_rd", READ_DATA_M, 0);
      cmp("clr_addr", BUS_ADDR, 0);
      next_cycle();
      CLR = 0; BUS_ACK = 1; BUS_RDATA = 32'hCAFEF00D;
      rd_model = 0; e_stall = 0; e_req = 0; e_rd = 0; e_mis = 0; e_to = 0;
      chk_en = 1;
      next_cycle();
      BUS_ACK = 0;
      do_op(1, 0, 2'd1, 1, 32'h702, 0, 32'h9ABC1234, 3);
      cmp("lit_after_clr_rd", READ_DATA_M, 32'hFFFF9ABC);

      for (int n = 0; n < 300; n++) begin
         logic rd, wr;
         logic [1:0] sz;
         logic [31:0] a;
         int k, d;
         k = $urandom_range(0, 9);
         rd = (k >= 1 && k <= 5) || k == 9;
         wr = (k >= 6);
         sz = 2'($urandom);
         a  = $urandom;
         if ($urandom_range(0, 3) != 0) a[1:0] = (sz == 2'd0) ? a[1:0] : (sz == 2'd1) ? {a[1], 1'b0} : 2'b00;
         d = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, TO);
         do_op(rd, wr, sz, 1'($urandom), a, $urandom, $urandom, d);
      end
      idle_op();
      chk_en = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
